// File: rtl/crypto_frame_pkg.sv
// Shared types and header defaults for the cipher-core frame loader.
// Holds the loader FSM state enum and the default mode header bytes.
package crypto_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KEY,
      DATA,
      CAPTURE,
      SEND
   } state_t;

   localparam logic [7:0] HDR_ENC_DEF = 8'hA5;
   localparam logic [7:0] HDR_DEC_DEF = 8'h5A;

endpackage

// File: rtl/crypto_frame_loader_frame_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while en is high, clr restarts it.
// Ports: clk, rst_n, clr, en in; expired out (combinational, one cycle).
module frame_gap_timer #(
   parameter int TIMEOUT_CYCLES = 1_200_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || !en) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // An accepted byte in the same cycle always beats the timeout.
   assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/crypto_frame_loader.sv
// Parses 3-byte frames (header, key, data) into cipher-core controls and
// returns the core result on a valid/ready byte port.
// Ports: rx_* byte input, core_* to/from cipher core, tx_* result output,
// frame_err pulse on bad header or timeout, busy when not IDLE.
module crypto_frame_loader
   import crypto_frame_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1_200_000,
   parameter logic [7:0] HDR_ENC        = HDR_ENC_DEF,
   parameter logic [7:0] HDR_DEC        = HDR_DEC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       core_sel,
   output logic [7:0] core_key,
   output logic [7:0] core_inp,
   input  logic [7:0] core_out,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       frame_err,
   output logic       busy
);

   state_t state_q, state_d;
   logic   rx_fire;
   logic   is_enc, is_dec;
   logic   expired;

   assign rx_ready = (state_q == IDLE) || (state_q == KEY) ||
                     (state_q == DATA);
   assign busy     = (state_q != IDLE);
   assign rx_fire  = rx_valid && rx_ready;
   assign is_enc   = (rx_data == HDR_ENC);
   assign is_dec   = (rx_data == HDR_DEC);

   frame_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (rx_fire),
      .en     ((state_q == KEY) || (state_q == DATA)),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rx_fire && (is_enc || is_dec)) state_d = KEY;
         KEY:     if (rx_fire) state_d = DATA;
                  else if (expired) state_d = IDLE;
         DATA:    if (rx_fire) state_d = CAPTURE;
                  else if (expired) state_d = IDLE;
         CAPTURE: state_d = SEND;
         SEND:    if (tx_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_sel  <= 1'b0;
         core_key  <= '0;
         core_inp  <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= expired;
         if (state_q == IDLE && rx_fire) begin
            if (is_enc)      core_sel  <= 1'b1;
            else if (is_dec) core_sel  <= 1'b0;
            else             frame_err <= 1'b1;
         end
         if (state_q == KEY && rx_fire)  core_key <= rx_data;
         if (state_q == DATA && rx_fire) core_inp <= rx_data;
         if (state_q == CAPTURE) begin
            tx_data  <= core_out;
            tx_valid <= 1'b1;
         end
         if (state_q == SEND && tx_ready) tx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_crypto_frame_loader.sv
// Directed bench for crypto_frame_loader with an XOR stand-in cipher core.
// Table of frames plus hand sequences for backpressure, timeout and reset.
module tb_crypto_frame_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic       core_sel;
   logic [7:0] core_key, core_inp, core_out;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       frame_err;
   logic       busy;

   int passed = 0;
   int total  = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   assign core_out = core_inp ^ core_key;

   crypto_frame_loader #(.TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .core_sel (core_sel),
      .core_key (core_key),
      .core_inp (core_inp),
      .core_out (core_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

   typedef struct {
      logic       use_pre;
      logic [7:0] pre;
      logic [7:0] hdr;
      logic [7:0] key;
      logic [7:0] dat;
      logic       sel;
      logic [7:0] tx;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      int e0;
      e0 = err_cnt;
      tx_ready = 1'b1;
      if (v.use_pre) begin
         send_byte(v.pre);
         chk("bad_hdr_err", frame_err, 1);
         chk("bad_hdr_idle", busy, 0);
      end
      send_byte(v.hdr);
      chk("hdr_busy", busy, 1);
      send_byte(v.key);
      send_byte(v.dat);
      chk("core_sel", core_sel, v.sel);
      chk("core_inp", core_inp, v.dat);
      chk("cap_rx_ready", rx_ready, 0);
      tick();
      chk("tx_valid_up", tx_valid, 1);
      chk("tx_data", tx_data, v.tx);
      tick();
      chk("tx_valid_down", tx_valid, 0);
      chk("rx_ready_back", rx_ready, 1);
      chk("err_pulses", err_cnt - e0, v.use_pre ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic ok;
      int   e0;

      vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'h3C, 8'h0F, 1'b1, 8'h33};
      vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h12, 8'h34, 1'b0, 8'h26};
      vecs[2] = '{1'b0, 8'h00, 8'hA5, 8'h5A, 8'hA5, 1'b1, 8'hFF};
      vecs[3] = '{1'b1, 8'h11, 8'hA5, 8'h01, 8'h02, 1'b1, 8'h03};
      vecs[4] = '{1'b0, 8'h00, 8'h5A, 8'hA5, 8'h5A, 1'b0, 8'hFF};

      tick();
      tick();
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_inp", core_inp, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      // Backpressure: result held, no timeout, no new bytes taken.
      e0 = err_cnt;
      tx_ready = 1'b0;
      send_byte(8'h5A);
      send_byte(8'hFF);
      send_byte(8'h00);
      chk("bp_sel", core_sel, 0);
      tick();
      chk("bp_tx_valid", tx_valid, 1);
      chk("bp_tx_data", tx_data, 8'hFF);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         ok &= tx_valid && (tx_data == 8'hFF) && !rx_ready &&
               busy && !frame_err;
      end
      chk("bp_hold", ok, 1);
      tx_ready = 1'b1;
      tick();
      chk("bp_release", tx_valid, 0);
      chk("bp_idle", busy, 0);
      chk("bp_no_err", err_cnt - e0, 0);

      // Timeout after the key byte.
      send_byte(8'hA5);
      send_byte(8'h01);
      ok = 1'b1;
      for (int i = 1; i < 16; i++) begin
         tick();
         ok &= !frame_err && busy;
      end
      chk("to_quiet", ok, 1);
      tick();
      chk("to_err", frame_err, 1);
      chk("to_busy", busy, 0);
      chk("to_rx_ready", rx_ready, 1);
      tick();
      chk("to_err_pulse", frame_err, 0);
      v = '{1'b0, 8'h00, 8'hA5, 8'h10, 8'h01, 1'b1, 8'h11};
      run_frame(v);

      // Data byte arrives on the very cycle the timeout would fire.
      e0 = err_cnt;
      send_byte(8'hA5);
      send_byte(8'h01);
      for (int i = 1; i < 16; i++) tick();
      send_byte(8'h77);
      chk("edge_no_err", frame_err, 0);
      chk("edge_busy", busy, 1);
      chk("edge_core_inp", core_inp, 8'h77);
      tick();
      chk("edge_tx_data", tx_data, 8'h76);
      chk("edge_tx_valid", tx_valid, 1);
      tick();
      chk("edge_done", tx_valid, 0);
      chk("edge_err_cnt", err_cnt - e0, 0);

      // Asynchronous reset while in SEND.
      tx_ready = 1'b0;
      send_byte(8'hA5);
      send_byte(8'hC3);
      send_byte(8'h3C);
      tick();
      chk("rs_pre_valid", tx_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_tx_valid", tx_valid, 0);
      chk("rs_tx_data", tx_data, 0);
      chk("rs_core_sel", core_sel, 0);
      chk("rs_core_key", core_key, 0);
      chk("rs_core_inp", core_inp, 0);
      chk("rs_busy", busy, 0);
      chk("rs_rx_ready", rx_ready, 1);
      chk("rs_frame_err", frame_err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      v = '{1'b0, 8'h00, 8'h5A, 8'h0F, 8'h0A, 1'b0, 8'h05};
      run_frame(v);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
